dmem_responder: RTL

//  Data-memory responder for the memory-stage data bus.
//  - Accepts one load/store request at a time from the memory stage and holds it for LATENCY cycles.
//  - Then returns one response beat: 64-bit read word, or write completion plus error flag.
//  - Sits on the far side of the bus whose read word feeds memory_data_t.regdata.
//  - Backing store is a DEPTH x 64-bit word array at byte address BASE.

---
 rtl/dmem_responder_pkg.sv | 51 +++++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared data-bus types for the memory-stage data responder.
// Holds the bus bundles, access sizes and the default array base address.
package dmem_responder_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic       valid;
        logic       write;
        addr_t      addr;
        msize_t     size;
        logic [7:0] strobe;
        word_t      wdata;
    } dbus_req_t;

    typedef struct packed {
        logic  ok;
        word_t data;
        logic  err;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_e;

    localparam addr_t DMEM_BASE = 64'h8000_0000;

    function automatic logic misaligned(msize_t sz, logic [2:0] lo);
        logic m;
        m = 1'b0;
        unique case (sz)
            MSIZE1:  m = 1'b0;
            MSIZE2:  m = lo[0];
            MSIZE4:  m = |lo[1:0];
            MSIZE8:  m = |lo;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit word store with per-byte write enables.
// Combinational read port, write committed on the rising edge.
module dmem_array #(
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] raddr_i,
    output logic [63:0]   rdata_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wbe_i,
    input  logic [63:0]   wdata_i
);

    logic [63:0] mem_q [DEPTH];

    assign rdata_o = mem_q[raddr_i];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 8; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: holds one request for LATENCY cycles,
// then returns a single registered response beat.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH   = 512,
    parameter logic [63:0] BASE    = DMEM_BASE,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        resp_ok,
    output logic [63:0] resp_data,
    output logic        resp_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [63:0] addr_q;
    msize_t      size_q;
    logic [7:0]  strobe_q;
    logic [63:0] wdata_q;
    logic        ready_q;
    logic        ok_q;
    logic        err_q;
    logic [63:0] data_q;

    logic          idle;
    logic          cur_write;
    logic [63:0]   cur_addr;
    msize_t        cur_size;
    logic [63:0]   offs;
    logic          oor;
    logic          err_d;
    logic [AW-1:0] idx;
    logic [63:0]   rdata;
    logic [63:0]   data_d;
    logic          we;

    // In IDLE the live request is decoded so LATENCY==1 can respond next edge.
    assign idle      = (state_q == S_IDLE);
    assign cur_write = idle ? req_write : write_q;
    assign cur_addr  = idle ? req_addr : addr_q;
    assign cur_size  = idle ? msize_t'(req_size) : size_q;

    assign offs   = cur_addr - BASE;
    assign oor    = (cur_addr < BASE) || ((offs >> 3) >= 64'(DEPTH));
    assign err_d  = oor || misaligned(cur_size, cur_addr[2:0]);
    assign idx    = offs[AW+2:3];
    assign data_d = (err_d || cur_write) ? '0 : rdata;
    assign we     = (state_q == S_RESP) && write_q && !err_q;

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk    (clk),
        .raddr_i(idx),
        .rdata_o(rdata),
        .we_i   (we),
        .waddr_i(idx),
        .wbe_i  (strobe_q),
        .wdata_i(wdata_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            size_q   <= MSIZE1;
            strobe_q <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b1;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            ok_q   <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        addr_q   <= req_addr;
                        size_q   <= msize_t'(req_size);
                        strobe_q <= req_strobe;
                        wdata_q  <= req_wdata;
                        cnt_q    <= CNT_INIT;
                        ready_q  <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q <= S_RESP;
                            ok_q    <= 1'b1;
                            err_q   <= err_d;
                            data_q  <= data_d;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                        ok_q    <= 1'b1;
                        err_q   <= err_d;
                        data_q  <= data_d;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign resp_ok   = ok_q;
    assign resp_data = data_q;
    assign resp_err  = err_q;

endmodule
